// File: rtl/q2_io_pkg.sv
// Shared definitions for the Q2 I/O device ports: command encodings,
// I2C sequencer states and the status word bit layout.
package q2_io_pkg;

    // Command field dbus[9:8] of an I2C port write word
    localparam logic [1:0] CMD_WRITE            = 2'b00;
    localparam logic [1:0] CMD_START_WRITE      = 2'b01;
    localparam logic [1:0] CMD_STOP             = 2'b10;
    localparam logic [1:0] CMD_START_WRITE_STOP = 2'b11;

    // Status word bit positions
    localparam int ST_BUSY    = 0;
    localparam int ST_ACK_ERR = 1;
    localparam int ST_OVERRUN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP
    } i2c_state_e;

    function automatic logic cmd_has_start(input logic [1:0] cmd);
        return (cmd == CMD_START_WRITE) || (cmd == CMD_START_WRITE_STOP);
    endfunction

    function automatic logic cmd_has_write(input logic [1:0] cmd);
        return cmd != CMD_STOP;
    endfunction

    function automatic logic cmd_has_stop(input logic [1:0] cmd);
        return (cmd == CMD_STOP) || (cmd == CMD_START_WRITE_STOP);
    endfunction

endpackage

// File: rtl/q2_tick_div.sv
// Quarter-bit prescaler: one-cycle tick every CLK_DIV clocks, restartable
// so the first phase of a transfer always gets a full tick period.
module q2_tick_div #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic clk,
    input  logic nrst,
    input  logic restart_i,
    output logic tick_o
);

    localparam logic [7:0] TC = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Terminal-count compare and next count
    always_comb begin
        tick_o = (cnt_q == TC);
        if (restart_i || tick_o) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register with synchronous clear
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/q2_i2c_port.sv
// Q2 I2C port: turns one I/O write word into a single-byte I2C master
// transfer on open-drain SCL/SDA and reports busy/NACK/overrun status.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transfer; lines held as left by the last transfer
// ST_START | q0: SDA low with SCL released, q1: SCL low
// ST_BIT   | 4 quarters per bit, MSB first; SCL released in q2/q3
// ST_ACK   | SDA released, SCL pulsed; sda_i sampled at end of q3
// ST_STOP  | q0: both low, q1: SCL released, q2: SDA released
module q2_i2c_port
    import q2_io_pkg::*;
#(
    parameter int unsigned CLK_DIV = 8,
    parameter int unsigned DATA_W  = 12
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i2c_wr,
    input  logic [DATA_W-1:0] dbus,
    input  logic              status_rd,
    input  logic              sda_i,
    output logic              scl_oe,
    output logic              sda_oe,
    output logic              busy,
    output logic [DATA_W-1:0] status
);

    i2c_state_e state_q, state_d;
    logic [1:0] qtr_q, qtr_d;
    logic [2:0] bit_q, bit_d;
    logic [1:0] cmd_q, cmd_d;
    logic [7:0] byte_q, byte_d;
    logic       idle_scl_q, idle_scl_d;
    logic       idle_sda_q, idle_sda_d;
    logic       ack_err_q, ack_err_d;
    logic       overrun_q, overrun_d;
    logic       busy_q, busy_d;

    logic       wr_q1, wr_q2;
    logic       wr_rise;
    logic [9:0] dbus_q;
    logic       restart;
    logic       tick;

    // Upper bus bits carry no meaning for this port
    logic dbus_unused;
    assign dbus_unused = ^dbus[DATA_W-1:10];

    assign wr_rise = wr_q1 & ~wr_q2;

    q2_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .nrst      (nrst),
        .restart_i (restart),
        .tick_o    (tick)
    );

    // Strobe edge detect; the bus word is latched on the first strobe cycle
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_q1  <= 1'b0;
            wr_q2  <= 1'b0;
            dbus_q <= 10'd0;
        end else begin
            wr_q1 <= i2c_wr;
            wr_q2 <= wr_q1;
            if (i2c_wr && !wr_q1) begin
                dbus_q <= dbus[9:0];
            end
        end
    end

    // Sequencer next state: every phase advances on one tick
    always_comb begin
        state_d    = state_q;
        qtr_d      = qtr_q;
        bit_d      = bit_q;
        cmd_d      = cmd_q;
        byte_d     = byte_q;
        idle_scl_d = idle_scl_q;
        idle_sda_d = idle_sda_q;
        ack_err_d  = ack_err_q;
        restart    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (wr_rise) begin
                    cmd_d   = dbus_q[9:8];
                    byte_d  = dbus_q[7:0];
                    qtr_d   = 2'd0;
                    bit_d   = 3'd7;
                    restart = 1'b1;
                    if (cmd_has_start(dbus_q[9:8])) begin
                        state_d = ST_START;
                    end else if (cmd_has_write(dbus_q[9:8])) begin
                        state_d = ST_BIT;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_START: begin
                if (tick) begin
                    if (qtr_q == 2'd1) begin
                        state_d = ST_BIT;
                        qtr_d   = 2'd0;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            ST_BIT: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        if (bit_q == 3'd0) begin
                            state_d = ST_ACK;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end
                end
            end
            ST_ACK: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        ack_err_d = sda_i;
                        if (cmd_has_stop(cmd_q)) begin
                            state_d = ST_STOP;
                        end else begin
                            // No STOP requested: keep SCL low to hold the bus
                            state_d    = ST_IDLE;
                            idle_scl_d = 1'b1;
                            idle_sda_d = 1'b0;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (qtr_q == 2'd2) begin
                        state_d    = ST_IDLE;
                        qtr_d      = 2'd0;
                        idle_scl_d = 1'b0;
                        idle_sda_d = 1'b0;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Overrun: a strobe during a transfer is dropped; set beats the read clear
    always_comb begin
        overrun_d = overrun_q;
        if (status_rd) begin
            overrun_d = 1'b0;
        end
        if (wr_rise && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Sequencer and status registers
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            qtr_q      <= 2'd0;
            bit_q      <= 3'd7;
            cmd_q      <= CMD_WRITE;
            byte_q     <= 8'd0;
            idle_scl_q <= 1'b0;
            idle_sda_q <= 1'b0;
            ack_err_q  <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            cmd_q      <= cmd_d;
            byte_q     <= byte_d;
            idle_scl_q <= idle_scl_d;
            idle_sda_q <= idle_sda_d;
            ack_err_q  <= ack_err_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
        end
    end

    // Line drivers decoded from the current phase
    always_comb begin
        scl_oe = idle_scl_q;
        sda_oe = idle_sda_q;
        unique case (state_q)
            ST_START: begin
                scl_oe = qtr_q[0];
                sda_oe = 1'b1;
            end
            ST_BIT: begin
                scl_oe = ~qtr_q[1];
                sda_oe = ~byte_q[bit_q];
            end
            ST_ACK: begin
                scl_oe = ~qtr_q[1];
                sda_oe = 1'b0;
            end
            ST_STOP: begin
                scl_oe = (qtr_q == 2'd0);
                sda_oe = (qtr_q != 2'd2);
            end
            default: begin
            end
        endcase
    end

    // CPU-visible status word
    always_comb begin
        status             = '0;
        status[ST_BUSY]    = busy_q;
        status[ST_ACK_ERR] = ack_err_q;
        status[ST_OVERRUN] = overrun_q;
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_q2_i2c_port.sv
// Directed bench for q2_i2c_port with an open-drain bus model and a
// simple byte responder that can ACK or NACK.
module tb_q2_i2c_port;

    logic        clk = 1'b0;
    logic        nrst;
    logic        i2c_wr;
    logic [11:0] dbus;
    logic        status_rd;
    logic        sda_i;
    logic        scl_oe;
    logic        sda_oe;
    logic        busy;
    logic [11:0] status;

    int vectors = 0;
    int miscompares = 0;

    // bus / responder model state
    logic ack_mode = 1'b1;
    logic pull = 1'b0;
    logic prev_scl = 1'b1;
    logic prev_sda = 1'b1;
    logic prev_busy = 1'b0;
    logic [7:0] shreg = 8'h00;
    logic [7:0] cap_byte = 8'hxx;
    logic cap_ack = 1'bx;
    int nbits = 0;
    int starts = 0;
    int stops = 0;
    int busy_len = 0;
    int busy_rises = 0;

    wire scl_line = ~scl_oe;
    wire sda_line = ~sda_oe & ~pull;
    assign sda_i = sda_line;

    always #5 clk = ~clk;

    q2_i2c_port #(
        .CLK_DIV (2),
        .DATA_W  (12)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .i2c_wr    (i2c_wr),
        .dbus      (dbus),
        .status_rd (status_rd),
        .sda_i     (sda_i),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .status    (status)
    );

    // Bus observer sampled mid-cycle: START/STOP, data bits, ACK, busy width
    always @(negedge clk) begin
        logic scl_now, sda_now;
        scl_now = ~scl_oe;
        sda_now = ~sda_oe & ~pull;
        if (busy && !prev_busy) begin
            nbits = 0;
            busy_len = 0;
            busy_rises++;
            cap_byte = 8'hxx;
            cap_ack = 1'bx;
        end
        if (busy) busy_len++;
        if (prev_scl && scl_now && prev_sda && !sda_now) begin
            starts++;
            nbits = 0;
        end
        if (prev_scl && scl_now && !prev_sda && sda_now) stops++;
        if (!prev_scl && scl_now) begin
            if (nbits < 8) shreg = {shreg[6:0], sda_now};
            if (nbits == 7) cap_byte = shreg;
            if (nbits == 8) cap_ack = sda_now;
            nbits++;
        end
        if (!scl_now) pull = ack_mode && (nbits == 8);
        prev_scl = scl_now;
        prev_sda = ~sda_oe & ~pull;
        prev_busy = busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [11:0] d, input int hold);
        @(negedge clk);
        dbus = d;
        i2c_wr = 1'b1;
        repeat (hold) @(negedge clk);
        i2c_wr = 1'b0;
        dbus = 12'h000;
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'(lvl));
    endtask

    task automatic pulse_rd();
        @(negedge clk);
        status_rd = 1'b1;
        @(negedge clk);
        status_rd = 1'b0;
    endtask

    initial begin
        int s0, p0, r0;
        nrst = 1'b0;
        i2c_wr = 1'b0;
        dbus = 12'h000;
        status_rd = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_status", 32'(status), 32'h000);
        check("rst_scl", 32'(scl_oe), 0);
        check("rst_sda", 32'(sda_oe), 0);
        nrst = 1'b1;

        // reset in the middle of a transfer
        send(12'h3A5, 1);
        wait_busy(1'b1, 10, "t1_busy_rise");
        repeat (10) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        check("t1_scl_rel", 32'(scl_oe), 0);
        check("t1_sda_rel", 32'(sda_oe), 0);
        repeat (2) @(negedge clk);
        check("t1_status", 32'(status), 32'h000);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // START+WRITE+STOP 0xA5, ACKed
        ack_mode = 1'b1;
        s0 = starts; p0 = stops;
        send(12'h3A5, 1);
        wait_busy(1'b1, 10, "t2_busy_rise");
        wait_busy(1'b0, 200, "t2_busy_fall");
        repeat (2) @(negedge clk);
        check("t2_busy_len", 32'(busy_len), 82);
        check("t2_byte", 32'(cap_byte), 32'hA5);
        check("t2_ack_bit", 32'(cap_ack), 0);
        check("t2_starts", 32'(starts - s0), 1);
        check("t2_stops", 32'(stops - p0), 1);
        check("t2_status", 32'(status), 32'h000);
        check("t2_scl_rel", 32'(scl_oe), 0);
        check("t2_sda_rel", 32'(sda_oe), 0);

        // same transfer, NACKed
        ack_mode = 1'b0;
        send(12'h3A5, 1);
        wait_busy(1'b1, 10, "t3_busy_rise");
        wait_busy(1'b0, 200, "t3_busy_fall");
        repeat (2) @(negedge clk);
        check("t3_busy_len", 32'(busy_len), 82);
        check("t3_ack_bit", 32'(cap_ack), 1);
        check("t3_status_nack", 32'(status), 32'h002);

        // plain WRITE 0x3C, ACKed: clears ack_err and holds the bus
        ack_mode = 1'b1;
        s0 = starts; p0 = stops;
        send(12'h03C, 1);
        wait_busy(1'b1, 10, "t3w_busy_rise");
        wait_busy(1'b0, 200, "t3w_busy_fall");
        repeat (2) @(negedge clk);
        check("t3w_busy_len", 32'(busy_len), 72);
        check("t3w_byte", 32'(cap_byte), 32'h3C);
        check("t3w_status", 32'(status), 32'h000);
        check("t3w_scl_hold", 32'(scl_oe), 1);
        check("t3w_sda", 32'(sda_oe), 0);
        check("t3w_no_start", 32'(starts - s0), 0);
        check("t3w_no_stop", 32'(stops - p0), 0);

        // STOP to release the held bus
        p0 = stops;
        send(12'h200, 1);
        wait_busy(1'b1, 10, "t3s_busy_rise");
        wait_busy(1'b0, 50, "t3s_busy_fall");
        repeat (2) @(negedge clk);
        check("t3s_busy_len", 32'(busy_len), 6);
        check("t3s_stops", 32'(stops - p0), 1);

        // START+WRITE 0x55 with strobe held 20 cycles
        s0 = starts; p0 = stops; r0 = busy_rises;
        send(12'h155, 20);
        wait_busy(1'b0, 200, "t4_busy_fall");
        repeat (10) @(negedge clk);
        check("t4_busy_len", 32'(busy_len), 76);
        check("t4_one_cmd", 32'(busy_rises - r0), 1);
        check("t4_byte", 32'(cap_byte), 32'h55);
        check("t4_ack_bit", 32'(cap_ack), 0);
        check("t4_starts", 32'(starts - s0), 1);
        check("t4_no_stop", 32'(stops - p0), 0);
        check("t4_scl_hold", 32'(scl_oe), 1);
        check("t4_status", 32'(status), 32'h000);

        // STOP only: phase by phase, CLK_DIV=2 cycles each
        p0 = stops;
        send(12'h200, 1);
        wait_busy(1'b1, 10, "t6_busy_rise");
        check("t6_p0_scl", 32'(scl_oe), 1);
        check("t6_p0_sda", 32'(sda_oe), 1);
        repeat (2) @(negedge clk);
        check("t6_p1_scl", 32'(scl_oe), 0);
        check("t6_p1_sda", 32'(sda_oe), 1);
        repeat (2) @(negedge clk);
        check("t6_p2_scl", 32'(scl_oe), 0);
        check("t6_p2_sda", 32'(sda_oe), 0);
        check("t6_p2_busy", 32'(busy), 1);
        repeat (2) @(negedge clk);
        check("t6_done_busy", 32'(busy), 0);
        check("t6_busy_len", 32'(busy_len), 6);
        check("t6_stops", 32'(stops - p0), 1);

        // write while busy -> overrun
        s0 = starts; r0 = busy_rises;
        send(12'h3A5, 1);
        wait_busy(1'b1, 10, "t5_busy_rise");
        repeat (3) @(negedge clk);
        send(12'h0FF, 1);
        repeat (2) @(negedge clk);
        check("t5_overrun_set", 32'(status), 32'h005);
        pulse_rd();
        check("t5_overrun_clr", 32'(status), 32'h001);
        // drop coincident with the read pulse: set wins
        @(negedge clk);
        dbus = 12'h0FF;
        i2c_wr = 1'b1;
        @(negedge clk);
        i2c_wr = 1'b0;
        dbus = 12'h000;
        status_rd = 1'b1;
        @(negedge clk);
        status_rd = 1'b0;
        check("t5_set_wins", 32'(status), 32'h005);
        wait_busy(1'b0, 200, "t5_busy_fall");
        repeat (2) @(negedge clk);
        check("t5_busy_len", 32'(busy_len), 82);
        check("t5_byte", 32'(cap_byte), 32'hA5);
        check("t5_one_cmd", 32'(busy_rises - r0), 1);
        check("t5_starts", 32'(starts - s0), 1);
        check("t5_status_idle", 32'(status), 32'h004);
        pulse_rd();
        check("t5_final_clr", 32'(status), 32'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
